// File: rtl/fetch_stage_pkg.sv
// Types and constants shared by the fetch stage and the decode control unit.
// Holds the fetch FSM encoding, the bubble instruction and the RV32I major opcodes.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_skid.sv
// Single-entry skid register: parks a fetched word that arrived while IF/ID was stalled.
// Clear wins over load so a redirect always empties it.
module fetch_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register with stall/redirect,
// and a skid entry that catches a word returning while the pipeline is stalled.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = PKG_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         started_q;

    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_pc, skid_instr;
    logic         handshake;

    fetch_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (req_pc_q),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // started_q keeps imem_req low until the first edge after reset release.
    assign imem_req  = started_q && (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign handshake = imem_req && imem_gnt;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        // Decode consumes IF/ID on every unstalled edge; refill below or leave a bubble.
        if (!stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end

        if (redirect) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear   = 1'b1;
            unique case (state_q)
                ST_REQ:  state_d = handshake ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                ST_HOLD: state_d = ST_REQ;
                ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (handshake) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = req_pc_q;
                            ifid_instr_d = imem_rdata;
                            state_d      = ST_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        if (skid_valid) begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = skid_pc;
                            ifid_instr_d = skid_instr;
                        end
                        skid_clear = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            started_q    <= 1'b1;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign opcode     = ifid_instr_q[6:0];
    assign func3      = ifid_instr_q[14:12];
    assign func7      = ifid_instr_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory, and a scoreboard of granted fetches
// popped whenever decode consumes a valid IF/ID entry.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = PKG_NOP_INSTR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int consumed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp_e;

    // memory model state
    int          lat = 0;
    bit          gnt_block = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    bit          hs_seen = 1'b0;
    logic [31:0] hs_addr = '0;
    bit          rv_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h0040_0093;
        return {a[24:0], 7'b0010011};
    endfunction

    // Memory: books the handshakes seen just before the edge, then drives gnt/rvalid.
    initial forever begin
        @(posedge clk);
        #1;
        if (hs_seen) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
            cnt       = lat;
        end else if (pend && rv_seen) begin
            pend = 1'b0;
        end else if (pend && cnt > 0) begin
            cnt = cnt - 1;
        end
        imem_rvalid = pend && (cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        imem_gnt    = imem_req && !pend && !gnt_block;
    end

    // Scoreboard monitor: inputs are final by negedge+1, outputs stable since the posedge.
    initial forever begin
        @(negedge clk);
        #1;
        hs_seen = imem_req && imem_gnt;
        hs_addr = imem_addr;
        rv_seen = imem_rvalid;
        if (!ifid_valid) begin
            checks++;
            if (ifid_instr !== NOP) begin
                errors++;
                $display("FAIL bubble_instr: got %h want %h", ifid_instr, NOP);
            end
        end
        if (!rst_n || redirect) begin
            exp_q.delete();
        end else begin
            if (ifid_valid && !stall) begin
                consumed++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got pc=%h instr=%h want none", ifid_pc, ifid_instr);
                end else begin
                    exp_e = exp_q.pop_front();
                    $display("consume pc=%h instr=%h", ifid_pc, ifid_instr);
                    if (ifid_pc !== exp_e.pc || ifid_instr !== exp_e.instr) begin
                        errors++;
                        $display("FAIL ifid_entry: got pc=%h instr=%h want pc=%h instr=%h",
                                 ifid_pc, ifid_instr, exp_e.pc, exp_e.instr);
                    end else if (opcode !== exp_e.instr[6:0] || func3 !== exp_e.instr[14:12] ||
                                 func7 !== exp_e.instr[31:25]) begin
                        errors++;
                        $display("FAIL decode_fields: got %b/%b/%b for instr %h",
                                 opcode, func3, func7, exp_e.instr);
                    end
                end
            end
            if (hs_seen) exp_q.push_back('{pc: imem_addr, instr: mem_word(imem_addr)});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // which: 0 req&gnt, 1 ifid_valid, 2 imem_req, 3 req&!gnt
    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((which == 0 && imem_req && imem_gnt) || (which == 1 && ifid_valid) ||
                (which == 2 && imem_req) || (which == 3 && imem_req && !imem_gnt)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP) begin
            errors++;
            $display("FAIL reset_state: got req=%b v=%b pc=%h instr=%h want 0/0/0/%h",
                     imem_req, ifid_valid, ifid_pc, ifid_instr, NOP);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_before_first_edge: got %b want 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_basic();
        bit ok;
        wait_for(1, 20, ok);
        checks++;
        if (!ok || ifid_pc !== 32'h0 || opcode !== OPC_OP) begin
            errors++;
            $display("FAIL basic_first: got ok=%b pc=%h opc=%b want pc=0 opc=%b", ok, ifid_pc, opcode, OPC_OP);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_bubble: got valid=%b want 0", ifid_valid);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || opcode !== OPC_OP_IMM) begin
            errors++;
            $display("FAIL basic_second: got v=%b pc=%h opc=%b want 1/4/%b", ifid_valid, ifid_pc, opcode, OPC_OP_IMM);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic sv;
        logic [31:0] spc, sin, addr;
        wait_for(0, 20, ok);
        addr  = imem_addr;
        stall = 1'b1;
        sv    = ifid_valid;
        spc   = ifid_pc;
        sin   = ifid_instr;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (!ok || ifid_valid !== sv || ifid_pc !== spc || ifid_instr !== sin || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h req=%b want v=%b pc=%h req=0",
                         i, ifid_valid, ifid_pc, imem_req, sv, spc);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== addr || ifid_instr !== mem_word(addr)) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h want 1/%h", ifid_valid, ifid_pc, addr);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_dup: got valid=%b pc=%h want 0", ifid_valid, ifid_pc);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        lat = 2;
        wait_for(0, 20, ok);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        checks++;
        if (!ok || imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got req=%b v=%b want 0/0", imem_req, ifid_valid);
        end
        wait_for(2, 20, ok);
        checks++;
        if (!ok || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_addr: got ok=%b addr=%h want 100", ok, imem_addr);
        end
        wait_for(1, 20, ok);
        checks++;
        if (!ok || ifid_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first: got ok=%b pc=%h want 100", ok, ifid_pc);
        end
        lat = 0;
    endtask

    task automatic test_redirect_stall();
        bit ok;
        wait_for(1, 20, ok);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        checks++;
        if (!ok || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
            errors++;
            $display("FAIL redir_stall_bubble: got v=%b instr=%h want 0/%h", ifid_valid, ifid_instr, NOP);
        end
        wait_for(2, 20, ok);
        checks++;
        if (!ok || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL redir_stall_addr: got ok=%b addr=%h want 200", ok, imem_addr);
        end
    endtask

    task automatic test_gnt_block();
        bit ok;
        logic [31:0] a0;
        gnt_block = 1'b1;
        wait_for(3, 20, ok);
        a0 = imem_addr;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (!ok || imem_req !== 1'b1 || imem_addr !== a0) begin
                errors++;
                $display("FAIL gnt_low_stable[%0d]: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, a0);
            end
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL redirect_no_gnt: got req=%b addr=%h want 1/300", imem_req, imem_addr);
        end
        gnt_block = 1'b0;
        wait_for(1, 20, ok);
        checks++;
        if (!ok || ifid_pc !== 32'h300) begin
            errors++;
            $display("FAIL redirect_no_gnt_first: got ok=%b pc=%h want 300", ok, ifid_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        lat = 3;
        wait_for(0, 20, ok);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP) begin
            errors++;
            $display("FAIL reset_async: got req=%b v=%b pc=%h instr=%h want 0/0/0/%h",
                     imem_req, ifid_valid, ifid_pc, ifid_instr, NOP);
        end
        tick();
        tick();
        rst_n = 1'b1;
        lat   = 0;
        wait_for(2, 20, ok);
        checks++;
        if (!ok || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_restart_addr: got ok=%b addr=%h want %h", ok, imem_addr, RST_PC);
        end
        wait_for(1, 20, ok);
        checks++;
        if (!ok || ifid_pc !== RST_PC || ifid_instr !== 32'h0000_0033) begin
            errors++;
            $display("FAIL reset_restart_word: got ok=%b pc=%h instr=%h want %h/00000033",
                     ok, ifid_pc, ifid_instr, RST_PC);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nvalid;
        logic [31:0] pcs[3];
        lat = 0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        wait_for(1, 30, ok);
        nvalid = 0;
        pcs[0] = ifid_pc;
        pcs[1] = '1;
        pcs[2] = '1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            if (ifid_valid) begin
                if (nvalid < 3) pcs[nvalid] = ifid_pc;
                nvalid++;
            end
        end
        checks++;
        if (!ok || nvalid != 10) begin
            errors++;
            $display("FAIL throughput: got %0d valid in 20 cycles want 10", nvalid);
        end
        checks++;
        if (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got %h %h %h want fffffff8 fffffffc 00000000", pcs[0], pcs[1], pcs[2]);
        end
    endtask

    task automatic test_random();
        int c0;
        c0 = consumed;
        for (int i = 0; i < 120; i++) begin
            tick();
            stall    = ($urandom_range(0, 3) == 0);
            lat      = $urandom_range(0, 2);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom & 32'h0000_0FFC;
        end
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (12) tick();
        checks++;
        if (consumed - c0 < 10) begin
            errors++;
            $display("FAIL random_progress: got %0d consumed want >= 10", consumed - c0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_gnt_block();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the bubble instruction presented when IF/ID holds no valid instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 stall  input  1  SHALL be the hazard-unit request to hold PC and IF/ID.
REQ-006 redirect  input  1  SHALL be the taken-branch/JAL/JALR request from the resolving stage.
REQ-007 redirect_pc  input  32  SHALL be the redirect target address.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  32  SHALL be the address for imem_req.
REQ-010 imem_gnt  input  1  SHALL be the memory acceptance of the request in the current cycle.
REQ-011 imem_rvalid  input  1  SHALL indicate imem_rdata is valid for the oldest accepted request.
REQ-012 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-013 ifid_valid  output  1  SHALL flag a valid instruction in IF/ID.
REQ-014 ifid_pc  output  32  SHALL be the PC of the IF/ID instruction.
REQ-015 ifid_instr  output  32  SHALL be the IF/ID instruction; NOP_INSTR when ifid_valid=0.
REQ-016 opcode 7, func3 3, func7 7  outputs  SHALL be combinational slices [6:0], [14:12], [31:25] of ifid_instr feeding the decode control unit.

Function
REQ-017 The block SHALL keep at most one outstanding memory request.
REQ-018 FSM states SHALL be REQ (drive imem_req), WAIT (accepted, awaiting rvalid), HOLD (word received, IF/ID stalled), DROP (awaiting rvalid of a request killed by redirect).
REQ-019 REQ: imem_req=1, imem_addr=pc; on imem_gnt go WAIT and pc<=pc+4 (32-bit wrap at 32'hFFFF_FFFC->0).
REQ-020 WAIT with imem_rvalid and stall=0: load IF/ID {pc_of_request, imem_rdata, valid=1}, go REQ the same edge (no bubble beyond memory latency).
REQ-021 WAIT with imem_rvalid and stall=1: buffer word in a skid register, go HOLD; IF/ID unchanged.
REQ-022 HOLD with stall=0: move skid word into IF/ID, go REQ.
REQ-023 With stall=1 and no rvalid, IF/ID and pc SHALL hold; an ungranted request SHALL keep imem_req asserted with stable imem_addr.
REQ-024 redirect SHALL have priority over stall: same edge pc<=redirect_pc, IF/ID<= {valid=0, NOP_INSTR}, skid emptied.
REQ-025 redirect in WAIT without same-cycle rvalid SHALL go DROP; DROP discards the next rvalid then goes REQ at redirect_pc.
REQ-026 redirect coincident with rvalid in WAIT SHALL discard the word and go REQ.
REQ-027 redirect in REQ coincident with imem_gnt SHALL go DROP; without gnt, next request uses redirect_pc.
REQ-028 redirect_pc SHALL be used as-is; bits [1:0] are not checked.
REQ-029 Fetch-to-IF/ID latency SHALL be memory latency +1 cycle; with zero-wait memory (gnt same cycle, rvalid next) throughput SHALL be one instruction per two cycles minimum, no instruction lost or duplicated.

Reset
REQ-030 rst_n low SHALL asynchronously set state=REQ, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, skid empty, imem_req=0 until first edge after release.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; rvalid arriving before the first post-reset grant SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, NOP_INSTR and opcode constants shared with the control unit.
REQ-033 One sub-module, fetch_skid, SHALL implement the single-entry skid buffer; all else inline.

Verification
REQ-034 Reset release, memory returns 32'h0000_0033 at 0x0 and 32'h0040_0093 at 0x4 -> IF/ID shows pc 0x0 then 0x4, opcode 7'b0110011 then 7'b0010011.
REQ-035 stall=1 for 3 cycles while rvalid arrives -> IF/ID unchanged, word emerges first cycle after stall drops, no duplicate.
REQ-036 redirect to 0x100 while WAIT -> in-flight word dropped, next imem_addr 0x100, ifid_valid=0 for the flush cycle.
REQ-037 redirect and stall same cycle -> redirect wins, pc=target, IF/ID bubble.
REQ-038 imem_gnt held low 4 cycles -> imem_req/imem_addr stable throughout.
REQ-039 rst_n pulsed low during WAIT -> outputs at reset values immediately, fetch restarts at RESET_PC.
